// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package hazard_pkg;

  localparam int REGW = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register an EX-stage load writes.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int W = REGW
) (
  input  logic         ex_mem_read_i,
  input  logic [W-1:0] ex_rd_i,
  input  logic [W-1:0] id_rs_i,
  input  logic [W-1:0] id_rt_i,
  input  logic         id_uses_rt_i,
  output logic         ld_use_o
);

  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rs_match = (ex_rd_i == id_rs_i);
  assign rt_match = id_uses_rt_i && (ex_rd_i == id_rt_i);
  assign ld_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: PC/latch enables and flushes for load-use, memory wait, branch squash and halt,
// plus saturating stall and flush perf counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int RW    = REGW,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ihit_i,
  input  logic             dmem_req_i,
  input  logic             dhit_i,
  input  logic [RW-1:0]    id_rs_i,
  input  logic [RW-1:0]    id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic [RW-1:0]    ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_tk_i,
  input  logic             wb_halt_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             mem_wb_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  hz_state_t        st_q, st_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             ld_use;
  logic             d_wait;

  hazard_detect #(.W(RW)) u_detect (
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .ld_use_o      (ld_use)
  );

  assign d_wait = (st_q != HALT) && dmem_req_i && !dhit_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q        <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (wb_halt_i) begin
      st_d = HALT;
    end else begin
      case (st_q)
        RUN:     if (dmem_req_i && !dhit_i) st_d = DWAIT;
        DWAIT:   if (dhit_i) st_d = RUN;
        HALT:    st_d = HALT;
        default: st_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b1;
    id_ex_flush_o  = 1'b0;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    mem_wb_flush_o = 1'b0;
    if (st_q == HALT) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      mem_wb_en_o = 1'b0;
    end else if (d_wait) begin
      // Everything up to EX/MEM freezes; WB retires a bubble while memory finishes.
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_flush_o = 1'b1;
    end else if (ex_branch_tk_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (ld_use) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end else if (!ihit_i) begin
      pc_en_o       = 1'b0;
      if_id_flush_o = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((st_q != HALT) && !pc_en_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if ((if_id_flush_o || id_ex_flush_o) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  assign halted_o    = (st_q == HALT);
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign state_o     = st_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed control vectors and counter values.
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  localparam int CW = 4;
  // Control vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush
  localparam logic [7:0] V_NORM  = 8'b1101_0110;
  localparam logic [7:0] V_LU    = 8'b0001_1110;
  localparam logic [7:0] V_DWAIT = 8'b0000_0011;
  localparam logic [7:0] V_BR    = 8'b1111_1110;
  localparam logic [7:0] V_FETCH = 8'b0111_0110;
  localparam logic [7:0] V_HALT  = 8'b0000_0000;

  logic clk = 1'b0;
  logic rst, ihit, dmem_req, dhit, id_uses_rt, ex_mem_read, ex_branch_tk, wb_halt;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush;
  logic halted;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0] state;
  logic [7:0] ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.RW(5), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ihit_i         (ihit),
    .dmem_req_i     (dmem_req),
    .dhit_i         (dhit),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rt_i   (id_uses_rt),
    .ex_rd_i        (ex_rd),
    .ex_mem_read_i  (ex_mem_read),
    .ex_branch_tk_i (ex_branch_tk),
    .wb_halt_i      (wb_halt),
    .pc_en_o        (pc_en),
    .if_id_en_o     (if_id_en),
    .if_id_flush_o  (if_id_flush),
    .id_ex_en_o     (id_ex_en),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_en_o    (ex_mem_en),
    .mem_wb_en_o    (mem_wb_en),
    .mem_wb_flush_o (mem_wb_flush),
    .halted_o       (halted),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt),
    .state_o        (state)
  );

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_branch_tk = 1'b0; wb_halt = 1'b0;
    id_rs = 5'd1; id_rt = 5'd2; ex_rd = 5'd3;
  endtask

  // Advance one clock; inputs may change afterwards and outputs settle 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();
    check("reset_state", 32'(state), 32'(RUN));
    check("reset_ctl", 32'(ctl), 32'(V_NORM));
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_stall", 32'(stall_cnt), 32'd0);
    check("reset_flush", 32'(flush_cnt), 32'd0);

    // 1: load-use on rs, then clean cycle
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; #1;
    check("lu_rs_ctl", 32'(ctl), 32'(V_LU));
    tick();
    ex_mem_read = 1'b0; #1;
    check("lu_after_ctl", 32'(ctl), 32'(V_NORM));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    check("lu_flush_cnt", 32'(flush_cnt), 32'd1);
    // rt match only counts when the instruction reads rt
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd4; id_rt = 5'd9; id_uses_rt = 1'b1; #1;
    check("lu_rt_ctl", 32'(ctl), 32'(V_LU));
    id_uses_rt = 1'b0; #1;
    check("lu_rt_unused_ctl", 32'(ctl), 32'(V_NORM));
    ihit = 1'b0; #1;
    check("fetch_bubble_ctl", 32'(ctl), 32'(V_FETCH));

    // 2: three D-wait cycles then dhit
    do_reset();
    dmem_req = 1'b1; dhit = 1'b0; #1;
    check("dw1_state", 32'(state), 32'(RUN));
    check("dw1_ctl", 32'(ctl), 32'(V_DWAIT));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("dw_state", 32'(state), 32'(DWAIT));
      check("dw_ctl", 32'(ctl), 32'(V_DWAIT));
    end
    tick();
    dhit = 1'b1; #1;
    check("dw_hit_state", 32'(state), 32'(DWAIT));
    check("dw_hit_ctl", 32'(ctl), 32'(V_NORM));
    check("dw_stall_cnt", 32'(stall_cnt), 32'd3);
    tick();
    dmem_req = 1'b0; dhit = 1'b0; #1;
    check("dw_exit_state", 32'(state), 32'(RUN));
    check("dw_exit_stall", 32'(stall_cnt), 32'd3);

    // 3: branch beats load-use and fetch miss
    do_reset();
    ex_branch_tk = 1'b1; ihit = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; #1;
    check("br_ctl", 32'(ctl), 32'(V_BR));
    tick();
    idle_inputs(); #1;
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd0);

    // 4: branch held off by D-wait, taken on the dhit cycle
    do_reset();
    ex_branch_tk = 1'b1; dmem_req = 1'b1; dhit = 1'b0; #1;
    check("brdw_ctl", 32'(ctl), 32'(V_DWAIT));
    tick();
    dhit = 1'b1; #1;
    check("brdw_hit_ctl", 32'(ctl), 32'(V_BR));
    tick();
    idle_inputs(); #1;
    check("brdw_flush_cnt", 32'(flush_cnt), 32'd1);
    check("brdw_stall_cnt", 32'(stall_cnt), 32'd1);

    // 5: halt during D-wait, then reset
    do_reset();
    dmem_req = 1'b1; dhit = 1'b0;
    tick();
    wb_halt = 1'b1; #1;
    check("halt_pre_state", 32'(state), 32'(DWAIT));
    check("halt_pre_halted", 32'(halted), 32'd0);
    check("halt_pre_ctl", 32'(ctl), 32'(V_DWAIT));
    tick();
    wb_halt = 1'b0; dhit = 1'b1; ex_branch_tk = 1'b1; #1;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_ctl", 32'(ctl), 32'(V_HALT));
    check("halt_stall_cnt", 32'(stall_cnt), 32'd2);
    tick(); tick();
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_ctl_hold", 32'(ctl), 32'(V_HALT));
    check("halt_stall_hold", 32'(stall_cnt), 32'd2);
    check("halt_flush_hold", 32'(flush_cnt), 32'd0);
    do_reset();
    check("halt_rst_state", 32'(state), 32'(RUN));
    check("halt_rst_halted", 32'(halted), 32'd0);
    check("halt_rst_stall", 32'(stall_cnt), 32'd0);

    // 6: ex_rd==0 never stalls; stall counter saturates
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
    check("rd0_ctl", 32'(ctl), 32'(V_NORM));
    ex_rd = 5'd5; id_rs = 5'd5;
    for (int i = 0; i < 15; i++) tick();
    check("sat_reach", 32'(stall_cnt), 32'd15);
    tick(); tick();
    check("sat_hold", 32'(stall_cnt), 32'd15);
    check("flush_sat", 32'(flush_cnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
